// File: rtl/present_pkg.sv
// PRESENT-128 shared constants: S-box table, round count,
// round counter width and the controller state encodings.
package present_pkg;

    localparam int ROUNDS = 31;
    localparam int CNT_W  = 5;

    // Nibble n of this word is S(n); index 0 sits in bits [3:0].
    localparam logic [63:0] SBOX_TABLE = 64'h2174_8FE3_DA09_B65C;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef logic [CNT_W-1:0] rnd_cnt_t;

endpackage

// File: rtl/present_sbox.sv
// PRESENT 4-bit S-box, a pure table lookup.
// Used for every data nibble and for the two key-schedule nibbles.
module present_sbox
    import present_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [3:0] o_nib
);

    assign o_nib = SBOX_TABLE[{i_nib, 2'b00} +: 4];

endmodule

// File: rtl/present_encrypt.sv
// Iterative PRESENT-128 encryptor: one round per clock,
// 31 rounds then whitening with K32.
module present_encrypt #(
    parameter int ROUNDS = present_pkg::ROUNDS
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [63:0]  plaintext,
    input  logic [127:0] key,
    output logic [63:0]  ciphertext,
    output logic         load_encrypt
);

    import present_pkg::*;

    localparam rnd_cnt_t LAST_RND = rnd_cnt_t'(ROUNDS);

    logic [1:0]   r_fsm;
    rnd_cnt_t     r_cnt;
    logic [63:0]  r_state;
    logic [127:0] r_key;
    logic [63:0]  r_ct;
    logic         r_done;

    logic [63:0]  w_rk;
    logic [63:0]  w_sin;
    logic [63:0]  w_sout;
    logic [63:0]  w_pout;
    logic [127:0] w_rot;
    logic [3:0]   w_ks_hi;
    logic [3:0]   w_ks_lo;
    logic [127:0] w_key_next;
    logic [63:0]  w_ct_next;

    assign w_rk  = r_key[127:64];
    assign w_sin = r_state ^ w_rk;

    for (genvar g = 0; g < 16; g++) begin : g_sbox
        present_sbox u_sbox (
            .i_nib (w_sin[4*g +: 4]),
            .o_nib (w_sout[4*g +: 4])
        );
    end

    // Bit i moves to (16*i) mod 63; bit 63 is fixed.
    for (genvar g = 0; g < 63; g++) begin : g_play
        assign w_pout[(16*g) % 63] = w_sout[g];
    end
    assign w_pout[63] = w_sout[63];

    // Key register rotated left by 61.
    assign w_rot = {r_key[66:0], r_key[127:67]};

    present_sbox u_ks_hi (
        .i_nib (w_rot[127:124]),
        .o_nib (w_ks_hi)
    );

    present_sbox u_ks_lo (
        .i_nib (w_rot[123:120]),
        .o_nib (w_ks_lo)
    );

    assign w_key_next = {
        w_ks_hi,
        w_ks_lo,
        w_rot[119:67],
        w_rot[66:62] ^ r_cnt,
        w_rot[61:0]
    };

    // After the last round the next key is K32.
    assign w_ct_next = w_pout ^ w_key_next[127:64];

    // Load capture, round iteration and result hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fsm   <= ST_IDLE;
            r_cnt   <= '0;
            r_state <= '0;
            r_key   <= '0;
            r_ct    <= '0;
            r_done  <= 1'b0;
        end else if (load) begin
            r_fsm   <= ST_BUSY;
            r_cnt   <= rnd_cnt_t'(1);
            r_state <= plaintext;
            r_key   <= key;
            r_done  <= 1'b0;
        end else begin
            case (r_fsm)
                ST_BUSY: begin
                    r_state <= w_pout;
                    r_key   <= w_key_next;
                    if (r_cnt == LAST_RND) begin
                        r_ct   <= w_ct_next;
                        r_done <= 1'b1;
                        r_cnt  <= '0;
                        r_fsm  <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + rnd_cnt_t'(1);
                    end
                end
                ST_DONE: begin
                    r_fsm <= ST_DONE;
                end
                ST_IDLE: begin
                    r_fsm <= ST_IDLE;
                end
                default: begin
                    r_fsm <= ST_IDLE;
                end
            endcase
        end
    end

    assign ciphertext   = r_ct;
    assign load_encrypt = r_done;

endmodule

// File: tb/tb_present_encrypt.sv
// Scoreboard bench for present_encrypt: expected ciphertexts
// are queued at load and checked when load_encrypt rises.
module tb_present_encrypt;

    logic         clk;
    logic         reset;
    logic         load;
    logic [63:0]  plaintext;
    logic [127:0] key;
    logic [63:0]  ciphertext;
    logic         load_encrypt;

    logic [63:0] exp_q[$];
    int vectors;
    int miscompares;

    localparam logic [127:0] K0   = 128'h0;
    localparam logic [127:0] K1   = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [63:0]  PT_A = 64'h4c746e677579656e;
    localparam logic [63:0]  CT_A = 64'h9ead5046c7164e1f;
    localparam logic [63:0]  PT_B = 64'h0123456789ABCDEF;
    localparam logic [63:0]  CT_B = 64'h0e9d28685e671dd6;
    localparam logic [63:0]  CT_Z = 64'h96db702a2e6900af;

    present_encrypt #(.ROUNDS(31)) dut (
        .clk          (clk),
        .reset        (reset),
        .load         (load),
        .plaintext    (plaintext),
        .key          (key),
        .ciphertext   (ciphertext),
        .load_encrypt (load_encrypt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag,
                         input logic [127:0] got,
                         input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One-cycle load; an earlier queued result is aborted.
    task automatic start(input logic [63:0] pt,
                         input logic [127:0] k,
                         input logic [63:0] exp);
        @(negedge clk);
        plaintext = pt;
        key       = k;
        load      = 1'b1;
        exp_q.delete();
        exp_q.push_back(exp);
        @(negedge clk);
        load = 1'b0;
    endtask

    // Wait for load_encrypt, optionally scrambling the inputs.
    task automatic wait_done(input string tag, input bit scramble);
        int n;
        bit seen;
        seen = 1'b0;
        n    = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (load_encrypt) begin
                n    = i;
                seen = 1'b1;
                break;
            end
            if (scramble) begin
                plaintext = {$urandom, $urandom};
                key = {$urandom, $urandom, $urandom, $urandom};
            end
        end
        if (!seen) begin
            check({tag, "_timeout"}, 0, 1);
        end else begin
            check({tag, "_latency"}, n, 31);
            if (exp_q.size() == 0)
                check({tag, "_spurious"}, 1, 0);
            else
                check({tag, "_ct"}, ciphertext, exp_q.pop_front());
        end
    endtask

    // Expect load_encrypt low for n edges.
    task automatic quiet(input string tag, input int n);
        int hits;
        hits = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (load_encrypt) hits++;
        end
        check(tag, hits, 0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        load        = 1'b0;
        plaintext   = '0;
        key         = '0;

        #2;
        check("rst_ct", ciphertext, 0);
        check("rst_flag", load_encrypt, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        quiet("idle_quiet", 5);

        start(PT_A, K0, CT_A);
        wait_done("vecA", 1'b0);

        start(PT_B, K1, CT_B);
        wait_done("vecB", 1'b0);

        start(64'h0, K0, CT_Z);
        wait_done("vecZ", 1'b0);
        for (int i = 0; i < 22; i++) begin
            @(posedge clk);
            #1;
            check("hold_ct", ciphertext, CT_Z);
            check("hold_flag", load_encrypt, 1);
        end

        start(PT_A, K0, CT_A);
        quiet("abort_quiet", 10);
        start(PT_B, K1, CT_B);
        wait_done("reload", 1'b0);

        start(PT_B, K1, CT_B);
        quiet("rst_busy", 5);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("async_ct", ciphertext, 0);
        check("async_flag", load_encrypt, 0);
        exp_q.delete();
        @(negedge clk);
        plaintext = PT_A;
        key       = K0;
        load      = 1'b1;
        @(negedge clk);
        @(negedge clk);
        load = 1'b0;
        check("rst_load_ct", ciphertext, 0);
        @(negedge clk);
        reset = 1'b1;
        quiet("post_rst", 40);
        check("post_rst_ct", ciphertext, 0);

        start(PT_A, K0, CT_A);
        wait_done("fresh", 1'b0);

        start(PT_B, K1, CT_B);
        wait_done("scramble", 1'b1);

        @(negedge clk);
        exp_q.delete();
        plaintext = 64'h0;
        key       = K0;
        load      = 1'b1;
        @(negedge clk);
        check("reload_clr", load_encrypt, 0);
        plaintext = PT_A;
        @(negedge clk);
        plaintext = PT_B;
        key       = K1;
        exp_q.push_back(CT_B);
        @(negedge clk);
        load = 1'b0;
        wait_done("held", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
